// File: rtl/ips2l_uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and data width.
// UART_RX_PARITY_EN adds the PARITY state.
package ips2l_uart_pkg;
  localparam int UART_DATA_W = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = S_IDLE, START = S_START, DATA = S_DATA, STOP = S_STOP, PARITY = S_PARITY
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE = S_IDLE, START = S_START, DATA = S_DATA, STOP = S_STOP
  } rx_state_t;
`endif
endpackage

// File: rtl/ips2l_uart_rx_fifo.sv
// Synchronous byte FIFO; a push while full is dropped and flagged on overflow.
module ips2l_uart_rx_fifo
  import ips2l_uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] pop_data,
  output logic [AW:0]            level,
  output logic                   empty,
  output logic                   overflow
);
  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, do_push, do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  // full is judged before any same-cycle pop, so a pop never makes room for the push
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      overflow <= push & full;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/ips2l_uart_rx_8bit.sv
// UART 8N1 receiver with byte FIFO and req/valid read port.
// UART_RX_PARITY_EN adds an even-parity bit before the stop bit.
module ips2l_uart_rx_8bit
  import ips2l_uart_pkg::*;
#(
  parameter int CLK_DIV    = 72,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rxd,
  output logic [UART_DATA_W-1:0] fifo_data,
  output logic                   fifo_data_valid,
  input  logic                   fifo_data_req,
  output logic [FIFO_AW:0]       fifo_level,
  output logic                   frame_err,
  output logic                   overflow
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV - 1);

  logic rxd_m, rxd_s, rxd_d, rxd_fall;
  rx_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] bit_idx, bit_nx;
  logic [UART_DATA_W-1:0] shreg, shreg_nx, rd_data;
  logic push, pop, ferr_nx, empty;
  logic par_err, par_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {rxd_m, rxd_s, rxd_d} <= 3'b111;
    else     {rxd_m, rxd_s, rxd_d} <= {uart_rxd, rxd_m, rxd_s};
  end
  assign rxd_fall = rxd_d & ~rxd_s;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    par_nx   = par_err;
    push     = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rxd_fall) state_nx = START;
      end
      START: if (cnt == CNT_HALF) begin
        cnt_nx   = '0;
        bit_nx   = '0;
        par_nx   = 1'b0;
        state_nx = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt == CNT_FULL) begin
        cnt_nx   = '0;
        shreg_nx = {rxd_s, shreg[UART_DATA_W-1:1]};
        bit_nx   = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_idx == 3'd7) state_nx = PARITY;
`else
        if (bit_idx == 3'd7) state_nx = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == CNT_FULL) begin
        cnt_nx   = '0;
        par_nx   = ^{shreg, rxd_s};
        state_nx = STOP;
      end
`endif
      STOP: if (cnt == CNT_FULL) begin
        // leaving at mid-stop leaves half a bit to catch a back-to-back start edge
        cnt_nx   = '0;
        state_nx = IDLE;
        if (rxd_s && !par_err) push = 1'b1;
        else                   ferr_nx = 1'b1;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_nx;
      shreg     <= shreg_nx;
      par_err   <= par_nx;
      frame_err <= ferr_nx;
    end
  end

  ips2l_uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(shreg),
    .pop      (pop),
    .pop_data (rd_data),
    .level    (fifo_level),
    .empty    (empty),
    .overflow (overflow)
  );

  // no pop in the valid cycle: caps throughput at one byte per two clocks
  assign pop = fifo_data_req & ~empty & ~fifo_data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data       <= '0;
      fifo_data_valid <= 1'b0;
    end else begin
      fifo_data_valid <= pop;
      if (pop) fifo_data <= rd_data;
    end
  end
endmodule

// File: tb/tb_ips2l_uart_rx_8bit.sv
// Directed bench for ips2l_uart_rx_8bit at CLK_DIV=8, FIFO_DEPTH=4.
module tb_ips2l_uart_rx_8bit;
  localparam int DIV = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1, uart_rxd = 1'b1, fifo_data_req = 1'b0;
  logic [7:0] fifo_data;
  logic fifo_data_valid, frame_err, overflow;
  logic [2:0] fifo_level;

  int checks = 0, errors = 0, cyc = 0;
  int ferr_cnt = 0, ovf_cnt = 0, dbl_vld = 0;
  logic prev_vld = 1'b0;
  logic [7:0] rxq[$];
  int rxcyc[$];

  ips2l_uart_rx_8bit #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd),
    .fifo_data(fifo_data), .fifo_data_valid(fifo_data_valid),
    .fifo_data_req(fifo_data_req), .fifo_level(fifo_level),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_data_valid) begin
        rxq.push_back(fifo_data);
        rxcyc.push_back(cyc);
      end
      if (fifo_data_valid && prev_vld) dbl_vld++;
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      prev_vld = fifo_data_valid;
    end else prev_vld = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1, input logic pflip = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pflip);
`endif
    send_bit(stop);
    uart_rxd = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int f0, o0;
    logic [7:0] d;
    wait_cyc(3);
    chk("rst_data", fifo_data, 8'h00);
    chk("rst_valid", fifo_data_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    wait_cyc(4);

    // single byte, req held
    fifo_data_req = 1'b1;
    send_byte(8'hA5);
    wait_cyc(8);
    chk("t1_cnt", rxq.size(), 1);
    if (rxq.size() > 0) chk("t1_data", rxq[0], 8'hA5);
    chk("t1_level", fifo_level, 0);
    chk("t1_hold", fifo_data, 8'hA5);
    chk("t1_vlow", fifo_data_valid, 0);
    rxq.delete(); rxcyc.delete();

    // three back-to-back bytes buffered, then drained
    fifo_data_req = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    wait_cyc(8);
    chk("t2_level", fifo_level, 3);
    chk("t2_novld", rxq.size(), 0);
    fifo_data_req = 1'b1;
    wait_cyc(12);
    fifo_data_req = 1'b0;
    chk("t2_cnt", rxq.size(), 3);
    for (int i = 0; i < 3 && i < rxq.size(); i++) chk($sformatf("t2_d%0d", i), rxq[i], i + 1);
    if (rxq.size() == 3) begin
      chk("t2_gap01", rxcyc[1] - rxcyc[0], 2);
      chk("t2_gap12", rxcyc[2] - rxcyc[1], 2);
    end
    chk("t2_level0", fifo_level, 0);
    rxq.delete(); rxcyc.delete();

    // overflow on 5th byte
    o0 = ovf_cnt;
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    wait_cyc(8);
    chk("t3_full", fifo_level, 4);
    chk("t3_noovf", ovf_cnt - o0, 0);
    send_byte(8'h05);
    wait_cyc(8);
    chk("t3_ovf", ovf_cnt - o0, 1);
    chk("t3_lvl", fifo_level, 4);
    fifo_data_req = 1'b1;
    wait_cyc(14);
    fifo_data_req = 1'b0;
    chk("t3_cnt", rxq.size(), 4);
    for (int i = 0; i < 4 && i < rxq.size(); i++) chk($sformatf("t3_d%0d", i), rxq[i], i + 1);
    rxq.delete(); rxcyc.delete();

    // framing error, then a good frame
    f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0);
    send_bit(1'b1);
    wait_cyc(4);
    chk("t4_ferr", ferr_cnt - f0, 1);
    chk("t4_lvl", fifo_level, 0);
    send_byte(8'h3C);
    wait_cyc(8);
    chk("t4_lvl1", fifo_level, 1);
    fifo_data_req = 1'b1;
    wait_cyc(4);
    fifo_data_req = 1'b0;
    chk("t4_cnt", rxq.size(), 1);
    if (rxq.size() > 0) chk("t4_data", rxq[0], 8'h3C);
    chk("t4_ferr1", ferr_cnt - f0, 1);
    rxq.delete(); rxcyc.delete();

    // start-bit glitch
    f0 = ferr_cnt;
    uart_rxd = 1'b0;
    wait_cyc(2);
    uart_rxd = 1'b1;
    wait_cyc(100);
    chk("t5_lvl", fifo_level, 0);
    chk("t5_ferr", ferr_cnt - f0, 0);

    // reset during data bit 4
    d = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    uart_rxd = d[4];
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(2);
    chk("t6_rvld", fifo_data_valid, 0);
    chk("t6_rlvl", fifo_level, 0);
    uart_rxd = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(4);
    fifo_data_req = 1'b1;
    send_byte(8'h5A);
    wait_cyc(8);
    chk("t6_cnt", rxq.size(), 1);
    if (rxq.size() > 0) chk("t6_data", rxq[0], 8'h5A);
    chk("t6_lvl", fifo_level, 0);
    rxq.delete(); rxcyc.delete();

`ifdef UART_RX_PARITY_EN
    f0 = ferr_cnt;
    send_byte(8'h5A, 1'b1, 1'b1);
    wait_cyc(8);
    chk("t7_ferr", ferr_cnt - f0, 1);
    chk("t7_cnt", rxq.size(), 0);
    chk("t7_lvl", fifo_level, 0);
`endif
    fifo_data_req = 1'b0;
    chk("valid_single", dbl_vld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
